hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces the fixed load-use compare with a shift-register scoreboard that tracks in-flight register writes across NSTAGE post-decode stages. From that table it produces stall, per-operand forward selects, and flush controls, and it counts stall and flush events. It sits beside the ID stage. The datapath consumes its outputs at the ID/EX boundary.

Parameters:
NSTAGE, 3, number of tracked stages after ID (entry 1 = EX … entry NSTAGE = WB)
NREGBITS, 5, register index width
ALU_DIST, 1, minimum entry index at which an ALU result is forwardable
LOAD_DIST, 2, minimum entry index at which a load result is forwardable
FLUSH_DEPTH, 2, entries (1..FLUSH_DEPTH) invalidated on redirect, plus the ID instruction
CNTW, 16, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  NREGBITS  ID source registers
id_use_rs, id_use_rt  in  1  source actually read
id_wrreg  in  NREGBITS  ID destination register
id_regwrite  in  1  ID instruction writes a register
id_memread  in  1  ID instruction is a load
redirect  in  1  branch taken or jump resolved (pcsrc | jump)
hold  in  1  pipeline freeze (multi-cycle data memory)
stall  out  1  hold IF/ID, bubble into EX
flush_id  out  1  clear the IF/ID register
flush_ex  out  1  clear entries younger than the redirecting instruction
fwd_a, fwd_b  out  clog2(NSTAGE+1)  registered forward select for EX; 0 = register file, k = producer k stages ahead
stall_cnt, flush_cnt  out  CNTW  saturating event counters

Behaviour:
- Table entry e[k], k = 1..NSTAGE, holds {valid, wrreg, is_load}. Register 0 is never tracked; an entry with wrreg = 0 is stored as invalid.
- Lookup is combinational for each used source s ≠ 0. It finds the smallest k with e[k].valid and e[k].wrreg == s.
  - Need = LOAD_DIST if e[k].is_load, else ALU_DIST.
  - k < need: hazard on s.
  - No match: select 0.
  - Only the youngest match counts. Older matches are ignored.
- stall = id_valid & (hazard_rs | hazard_rt) & ~redirect.
- flush_id = flush_ex = redirect & ~hold. Both are combinational.
- Update on each posedge, priority from highest to lowest:
  1. reset: all entries invalid; fwd_a/b = 0; counters = 0.
  2. hold: table, fwd and counters frozen. redirect and stall are ignored; the datapath keeps redirect asserted until hold drops.
  3. redirect: e[1..FLUSH_DEPTH] cleared and the shift still occurs. The new e[1] is a bubble, and e[FLUSH_DEPTH+1..] shift normally. fwd_a/b = 0. flush_cnt increments.
  4. stall: e[k+1] ← e[k]; e[1] ← bubble; fwd_a/b = 0; stall_cnt increments.
  5. normal: shift; e[1] ← {id_valid & id_regwrite, id_wrreg, id_memread}; fwd_a/b ← match index (0 if unused or no match).
- e[NSTAGE] retires on shift. The register file does write-before-read, so a retired value is read from the register file.
- Latency: stall and flush act in the same cycle. fwd_a/b are valid in the cycle the consumer occupies EX, i.e. one cycle after lookup.
- Counters saturate at all-ones and do not wrap.
- Simultaneous redirect and stall: redirect wins and stall is deasserted. The stalled instruction is on the wrong path.
- Reset asserted mid-stall or mid-flush: the next cycle has an empty table, so stall = 0.
- Reset values: stall = 0, flush_id = flush_ex = 0 (redirect low), fwd_a = fwd_b = 0, both counters 0.

Decomposition:
- Package hazard_pkg holds:
  - entry struct {valid, wrreg, is_load}
  - FWD_RF = 0
  - width helper function for the fwd select
- One natural sub-module, hazard_match: combinational youngest-match and ready-check for one source operand. It is instanced twice (rs, rt).

Test Plan:
- lw r1 then add r2,r1,r3 back-to-back (defaults) -> stall = 1 for exactly 1 cycle; the add then sees fwd_a = 2; stall_cnt = 1.
- add r1 then sub r4,r1,r1 -> no stall; fwd_a = fwd_b = 1 in the sub's EX cycle.
- add r1, add r1, or r5,r1,r0 -> youngest match wins, fwd_a = 1; r0 operand gives fwd_b = 0; r0 destination never stalls.
- Redirect in the same cycle as a pending load-use stall -> stall = 0, flush_id = flush_ex = 1, e[1..2] invalid next cycle, flush_cnt = 1, stall_cnt = 0.
- hold high for 3 cycles during a load-use hazard -> table, fwd and counters unchanged; after hold falls, exactly one stall cycle occurs.
- Force stall for 2^CNTW+5 cycles, then reset mid-stall -> stall_cnt saturates at 0xFFFF; the cycle after reset shows stall = 0 and counters = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type and forward-select helpers
package hazard_pkg;
   localparam int MAXREG = 8;
   localparam int FWD_RF = 0;
   typedef struct packed {
      logic              valid;
      logic [MAXREG-1:0] wrreg;
      logic              is_load;
   } entry_t;
   function automatic int fwd_w(input int nstage);
      return $clog2(nstage + 1);
   endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and hazard-control response bundle
interface hazard_scoreboard_if #(
   parameter int NSTAGE   = 3,
   parameter int NREGBITS = 5,
   parameter int CNTW     = 16
);
   localparam int FW = hazard_pkg::fwd_w(NSTAGE);
   logic                id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
   logic [NREGBITS-1:0] id_rs, id_rt, id_wrreg;
   logic                redirect, hold;
   logic                stall, flush_id, flush_ex;
   logic [FW-1:0]       fwd_a, fwd_b;
   logic [CNTW-1:0]     stall_cnt, flush_cnt;
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wrreg, id_regwrite, id_memread, redirect, hold,
      input  stall, flush_id, flush_ex, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wrreg, id_regwrite, id_memread, redirect, hold,
      output stall, flush_id, flush_ex, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest in-flight producer lookup and readiness check for one source operand
module hazard_match import hazard_pkg::*; #(
   parameter int NSTAGE    = 3,
   parameter int NREGBITS  = 5,
   parameter int ALU_DIST  = 1,
   parameter int LOAD_DIST = 2,
   parameter int FW        = 2
) (
   input  entry_t [NSTAGE:1]   tbl,
   input  logic [NREGBITS-1:0] src,
   input  logic                use_src,
   output logic [FW-1:0]       sel,
   output logic                hazard
);
   // scan oldest to youngest so the youngest match overwrites any older one
   always_comb begin
      sel = FW'(FWD_RF);
      hazard = 1'b0;
      for (int k = NSTAGE; k >= 1; k--)
         if (use_src && src != '0 && tbl[k].valid && tbl[k].wrreg == MAXREG'(src)) begin
            sel = FW'(k);
            hazard = k < (tbl[k].is_load ? LOAD_DIST : ALU_DIST);
         end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard producing stall, forward selects and flush controls
module hazard_scoreboard import hazard_pkg::*; #(
   parameter int NSTAGE      = 3,
   parameter int NREGBITS    = 5,
   parameter int ALU_DIST    = 1,
   parameter int LOAD_DIST   = 2,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNTW        = 16
) (
   input logic clk,
   input logic reset,
   hazard_scoreboard_if.slave bus
);
   localparam int FW = fwd_w(NSTAGE);
   entry_t [NSTAGE:1] tbl_q, tbl_d;
   entry_t            id_e;
   logic [FW-1:0]     fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
   logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic              hz_a, hz_b, stall, flush, bubble;

   hazard_match #(.NSTAGE(NSTAGE), .NREGBITS(NREGBITS), .ALU_DIST(ALU_DIST), .LOAD_DIST(LOAD_DIST), .FW(FW)) u_match_a (
      .tbl(tbl_q), .src(bus.id_rs), .use_src(bus.id_use_rs), .sel(sel_a), .hazard(hz_a)
   );
   hazard_match #(.NSTAGE(NSTAGE), .NREGBITS(NREGBITS), .ALU_DIST(ALU_DIST), .LOAD_DIST(LOAD_DIST), .FW(FW)) u_match_b (
      .tbl(tbl_q), .src(bus.id_rt), .use_src(bus.id_use_rt), .sel(sel_b), .hazard(hz_b)
   );

   // same-cycle controls; a redirect squashes the stall because ID is on the wrong path
   always_comb begin
      stall = bus.id_valid & (hz_a | hz_b) & ~bus.redirect;
      flush = bus.redirect & ~bus.hold;
      bubble = bus.redirect | stall;
      id_e = '{valid: bus.id_valid & bus.id_regwrite & (bus.id_wrreg != '0), wrreg: MAXREG'(bus.id_wrreg), is_load: bus.id_memread};
   end

   assign bus.stall     = stall;
   assign bus.flush_id  = flush;
   assign bus.flush_ex  = flush;
   assign bus.fwd_a     = fwd_a_q;
   assign bus.fwd_b     = fwd_b_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

   // table shift with squash/bubble insertion, forward capture and saturating counts; hold freezes all
   always_comb begin
      tbl_d = tbl_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!bus.hold) begin
         for (int k = 2; k <= NSTAGE; k++)
            tbl_d[k] = (bus.redirect && k - 1 <= FLUSH_DEPTH) ? '0 : tbl_q[k-1];
         tbl_d[1] = bubble ? '0 : id_e;
         fwd_a_d = bubble ? FW'(FWD_RF) : sel_a;
         fwd_b_d = bubble ? FW'(FWD_RF) : sel_b;
         stall_cnt_d = stall_cnt_q + CNTW'(stall && !(&stall_cnt_q));
         flush_cnt_d = flush_cnt_q + CNTW'(bus.redirect && !(&flush_cnt_q));
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         tbl_q <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         tbl_q <= tbl_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall, forwarding, flush, hold and counter saturation
module tb_hazard_scoreboard;
   logic clk = 1'b0, reset = 1'b1, sat_reset = 1'b1;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;

   hazard_scoreboard_if bus ();
   hazard_scoreboard_if #(.NSTAGE(8)) sbus ();

   hazard_scoreboard u_dut (.clk(clk), .reset(reset), .bus(bus));
   hazard_scoreboard #(.NSTAGE(8), .LOAD_DIST(9)) u_sat (.clk(clk), .reset(sat_reset), .bus(sbus));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] wr, input logic rw, input logic mr);
      bus.id_valid = v; bus.id_rs = rs; bus.id_use_rs = urs; bus.id_rt = rt; bus.id_use_rt = urt;
      bus.id_wrreg = wr; bus.id_regwrite = rw; bus.id_memread = mr;
      #1;
   endtask

   initial begin
      bus.redirect = 1'b0; bus.hold = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      sbus.redirect = 1'b0; sbus.hold = 1'b0;
      sbus.id_valid = 1'b1; sbus.id_rs = 5'd1; sbus.id_use_rs = 1'b1; sbus.id_rt = 5'd0; sbus.id_use_rt = 1'b0;
      sbus.id_wrreg = 5'd1; sbus.id_regwrite = 1'b1; sbus.id_memread = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("rst_stall", bus.stall, 0);
      check("rst_flush_id", bus.flush_id, 0);
      check("rst_flush_ex", bus.flush_ex, 0);
      check("rst_fwd_a", bus.fwd_a, 0);
      check("rst_fwd_b", bus.fwd_b, 0);
      check("rst_stall_cnt", bus.stall_cnt, 0);
      check("rst_flush_cnt", bus.flush_cnt, 0);
      // lw r1 ; add r2,r1,r3
      set_id(1, 2, 1, 0, 0, 1, 1, 1);
      check("lw_no_stall", bus.stall, 0);
      tick();
      set_id(1, 1, 1, 3, 1, 2, 1, 0);
      check("lu_stall", bus.stall, 1);
      tick();
      check("lu_stall_once", bus.stall, 0);
      check("lu_fwd_bubble", bus.fwd_a, 0);
      check("lu_cnt", bus.stall_cnt, 1);
      tick();
      check("lu_fwd_a", bus.fwd_a, 2);
      check("lu_fwd_b", bus.fwd_b, 0);
      // add r1 ; sub r4,r1,r1
      set_id(1, 2, 1, 3, 1, 1, 1, 0);
      tick();
      set_id(1, 1, 1, 1, 1, 4, 1, 0);
      check("alu_no_stall", bus.stall, 0);
      tick();
      check("alu_fwd_a", bus.fwd_a, 1);
      check("alu_fwd_b", bus.fwd_b, 1);
      check("alu_cnt", bus.stall_cnt, 1);
      // add r1 ; add r1 ; or r5,r1,r0
      set_id(1, 2, 1, 3, 1, 1, 1, 0);
      tick();
      tick();
      set_id(1, 1, 1, 0, 1, 5, 1, 0);
      check("young_no_stall", bus.stall, 0);
      tick();
      check("young_fwd_a", bus.fwd_a, 1);
      check("r0_fwd_b", bus.fwd_b, 0);
      // lw r0 ; add r6,r0,r0
      set_id(1, 2, 1, 0, 0, 0, 1, 1);
      tick();
      set_id(1, 0, 1, 0, 1, 6, 1, 0);
      check("r0_dst_no_stall", bus.stall, 0);
      tick();
      check("r0_dst_fwd_a", bus.fwd_a, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      // redirect against a pending load-use stall
      set_id(1, 2, 1, 0, 0, 1, 1, 1);
      tick();
      set_id(1, 1, 1, 0, 0, 2, 1, 0);
      bus.redirect = 1'b1;
      #1;
      check("rd_stall_masked", bus.stall, 0);
      check("rd_flush_id", bus.flush_id, 1);
      check("rd_flush_ex", bus.flush_ex, 1);
      tick();
      bus.redirect = 1'b0;
      #1;
      check("rd_flush_cnt", bus.flush_cnt, 1);
      check("rd_stall_cnt", bus.stall_cnt, 1);
      check("rd_fwd_a", bus.fwd_a, 0);
      check("rd_squashed", bus.stall, 0);
      tick();
      check("rd_no_fwd", bus.fwd_a, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      // hold during a load-use hazard: add r2 ; lw r1,(r2) ; add r3,r1
      set_id(1, 3, 0, 4, 0, 2, 1, 0);
      tick();
      set_id(1, 2, 1, 0, 0, 1, 1, 1);
      tick();
      check("hd_pre_fwd", bus.fwd_a, 1);
      set_id(1, 1, 1, 0, 0, 3, 1, 0);
      bus.hold = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hd_stall", bus.stall, 1);
         tick();
         check("hd_fwd_frozen", bus.fwd_a, 1);
         check("hd_cnt_frozen", bus.stall_cnt, 1);
      end
      bus.redirect = 1'b1;
      #1;
      check("hd_no_flush", bus.flush_id, 0);
      tick();
      check("hd_flush_cnt", bus.flush_cnt, 1);
      bus.redirect = 1'b0;
      bus.hold = 1'b0;
      #1;
      check("hd_release_stall", bus.stall, 1);
      tick();
      check("hd_one_stall_cnt", bus.stall_cnt, 2);
      check("hd_one_stall", bus.stall, 0);
      check("hd_bubble_fwd", bus.fwd_a, 0);
      tick();
      check("hd_fwd_load", bus.fwd_a, 2);
      // saturation on the deep-load instance, then reset mid-stall
      sat_reset = 1'b0;
      for (int i = 0; i < 73800; i++) @(posedge clk);
      #1;
      for (int i = 0; i < 20 && !sbus.stall; i++) tick();
      check("sat_mid_stall", sbus.stall, 1);
      check("sat_stall_cnt", sbus.stall_cnt, 32'hFFFF);
      check("sat_flush_cnt", sbus.flush_cnt, 0);
      sat_reset = 1'b1;
      tick();
      sat_reset = 1'b0;
      #1;
      check("sat_rst_stall", sbus.stall, 0);
      check("sat_rst_stall_cnt", sbus.stall_cnt, 0);
      check("sat_rst_flush_cnt", sbus.flush_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
